// File: rtl/rx_bringup_sequencer.sv
// PCS receive-chain bring-up sequencer: enables block sync, AM aligner, deskewer and
// the tail stages in order, retrying with a soft reset on timeout or link loss.
module rx_bringup_sequencer #(
    parameter int unsigned N_LANES       = 20,
    parameter int unsigned NB_TIMEOUT    = 24,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RESET_CYCLES  = 8,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned NB_RETRY      = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [NB_TIMEOUT-1:0] i_rf_timeout_limit,
    input  logic [N_LANES-1:0]    i_lanes_block_lock,
    input  logic [N_LANES-1:0]    i_am_lock,
    input  logic                  i_invalid_skew,
    output logic                  o_enb_block_sync,
    output logic                  o_enb_aligner,
    output logic                  o_enb_deskewer,
    output logic                  o_enb_lane_reorder,
    output logic                  o_enb_descrambler,
    output logic                  o_enb_decoder,
    output logic                  o_rx_soft_reset,
    output logic                  o_busy,
    output logic                  o_link_up,
    output logic                  o_fail,
    output logic [2:0]            o_state,
    output logic [NB_RETRY-1:0]   o_retry_count
);

    localparam int unsigned NB_SETTLE = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_BLK    = 3'd1,
        ST_WAIT_AM     = 3'd2,
        ST_WAIT_DESKEW = 3'd3,
        ST_ENB_TAIL    = 3'd4,
        ST_LINK_UP     = 3'd5,
        ST_RESTART     = 3'd6,
        ST_FAIL        = 3'd7
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NB_SETTLE-1:0]  settle_cnt;
    logic [NB_SETTLE-1:0]  settle_cnt_nxt;
    logic [NB_TIMEOUT-1:0] phase_cnt;
    logic [NB_TIMEOUT-1:0] phase_cnt_nxt;
    logic [NB_RETRY-1:0]   retry_cnt;
    logic [NB_RETRY-1:0]   retry_cnt_nxt;
    logic [NB_RETRY-1:0]   retry_base;

    logic blk_ok;
    logic am_ok;
    logic deskew_ok;
    logic in_wait;
    logic cond;
    logic settled;
    logic timed_out;
    logic restart_req;

    assign blk_ok    = &i_lanes_block_lock;
    assign am_ok     = blk_ok & (&i_am_lock);
    assign deskew_ok = am_ok & ~i_invalid_skew;

    // Phase condition of the current wait state
    always_comb begin
        in_wait = 1'b0;
        cond    = 1'b0;
        case (state)
            ST_WAIT_BLK:    begin in_wait = 1'b1; cond = blk_ok;    end
            ST_WAIT_AM:     begin in_wait = 1'b1; cond = am_ok;     end
            ST_WAIT_DESKEW: begin in_wait = 1'b1; cond = deskew_ok; end
            default:        ;
        endcase
    end

    // phase_cnt holds the cycles already spent in the state, so a wait state lasts at most limit cycles
    assign settled   = cond & (settle_cnt == NB_SETTLE'(SETTLE_CYCLES - 1));
    assign timed_out = in_wait & (i_rf_timeout_limit != '0)
                     & (phase_cnt >= (i_rf_timeout_limit - NB_TIMEOUT'(1)));

    always_comb begin
        state_nxt     = state;
        retry_cnt_nxt = retry_cnt;
        retry_base    = retry_cnt;
        restart_req   = 1'b0;

        case (state)
            ST_IDLE, ST_FAIL: begin
                if (i_start) begin
                    state_nxt     = ST_WAIT_BLK;
                    retry_cnt_nxt = '0;
                end
            end
            ST_WAIT_BLK: begin
                if (settled)        state_nxt   = ST_WAIT_AM;
                else if (timed_out) restart_req = 1'b1;
            end
            ST_WAIT_AM: begin
                if (settled)        state_nxt   = ST_WAIT_DESKEW;
                else if (timed_out) restart_req = 1'b1;
            end
            ST_WAIT_DESKEW: begin
                if (settled)        state_nxt   = ST_ENB_TAIL;
                else if (timed_out) restart_req = 1'b1;
            end
            ST_ENB_TAIL: state_nxt = ST_LINK_UP;
            ST_LINK_UP: begin
                if (!deskew_ok) begin
                    restart_req = 1'b1;
                    retry_base  = '0;
                end
            end
            ST_RESTART: begin
                if (phase_cnt == NB_TIMEOUT'(RESET_CYCLES - 1)) state_nxt = ST_WAIT_BLK;
            end
            default: ;
        endcase

        // Exhausted retries skip RESTART entirely so no soft-reset pulse is issued
        if (restart_req) begin
            if (retry_base == NB_RETRY'(MAX_RETRIES)) begin
                state_nxt     = ST_FAIL;
                retry_cnt_nxt = retry_base;
            end else begin
                state_nxt     = ST_RESTART;
                retry_cnt_nxt = retry_base + NB_RETRY'(1);
            end
        end

        if (i_abort) begin
            state_nxt     = ST_IDLE;
            retry_cnt_nxt = '0;
        end

        settle_cnt_nxt = '0;
        phase_cnt_nxt  = '0;
        if (!i_abort && (state_nxt == state)) begin
            if (cond) settle_cnt_nxt = settle_cnt + NB_SETTLE'(1);
            if (in_wait || (state == ST_RESTART)) begin
                phase_cnt_nxt = (phase_cnt == '1) ? phase_cnt : phase_cnt + NB_TIMEOUT'(1);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            phase_cnt  <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            phase_cnt  <= phase_cnt_nxt;
            retry_cnt  <= retry_cnt_nxt;
        end
    end

    // Moore outputs registered from the next state so they align with o_state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_enb_block_sync   <= 1'b0;
            o_enb_aligner      <= 1'b0;
            o_enb_deskewer     <= 1'b0;
            o_enb_lane_reorder <= 1'b0;
            o_enb_descrambler  <= 1'b0;
            o_enb_decoder      <= 1'b0;
            o_rx_soft_reset    <= 1'b0;
            o_busy             <= 1'b0;
            o_link_up          <= 1'b0;
            o_fail             <= 1'b0;
        end else begin
            o_enb_block_sync   <= (state_nxt >= ST_WAIT_BLK) && (state_nxt <= ST_LINK_UP);
            o_enb_aligner      <= (state_nxt >= ST_WAIT_AM) && (state_nxt <= ST_LINK_UP);
            o_enb_deskewer     <= (state_nxt >= ST_WAIT_DESKEW) && (state_nxt <= ST_LINK_UP);
            o_enb_lane_reorder <= (state_nxt == ST_ENB_TAIL) || (state_nxt == ST_LINK_UP);
            o_enb_descrambler  <= (state_nxt == ST_ENB_TAIL) || (state_nxt == ST_LINK_UP);
            o_enb_decoder      <= (state_nxt == ST_ENB_TAIL) || (state_nxt == ST_LINK_UP);
            o_rx_soft_reset    <= (state_nxt == ST_RESTART);
            o_busy             <= ((state_nxt >= ST_WAIT_BLK) && (state_nxt <= ST_ENB_TAIL))
                                || (state_nxt == ST_RESTART);
            o_link_up          <= (state_nxt == ST_LINK_UP);
            o_fail             <= (state_nxt == ST_FAIL);
        end
    end

    assign o_state       = 3'(state);
    assign o_retry_count = retry_cnt;

endmodule

// File: tb/tb_rx_bringup_sequencer.sv
// Bench for rx_bringup_sequencer: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the bring-up rules.
module tb_rx_bringup_sequencer;

    localparam int unsigned N_LANES      = 20;
    localparam int unsigned NB_TIMEOUT   = 24;
    localparam int unsigned SETTLE       = 4;
    localparam int unsigned RESET_CYCLES = 8;
    localparam int unsigned MAX_RETRIES  = 2;
    localparam int unsigned NB_RETRY     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic [NB_TIMEOUT-1:0] limit;
    logic [N_LANES-1:0]    lanes_blk;
    logic [N_LANES-1:0]    am_lock;
    logic                  skew;

    logic                  o_enb_block_sync;
    logic                  o_enb_aligner;
    logic                  o_enb_deskewer;
    logic                  o_enb_lane_reorder;
    logic                  o_enb_descrambler;
    logic                  o_enb_decoder;
    logic                  o_rx_soft_reset;
    logic                  o_busy;
    logic                  o_link_up;
    logic                  o_fail;
    logic [2:0]            o_state;
    logic [NB_RETRY-1:0]   o_retry_count;
    logic [14:0]           obs;

    int n_run  = 0;
    int n_fail = 0;

    // Model: state number, cycles spent in it, consecutive-true streak, retries
    int m_state;
    int m_cnt;
    int m_streak;
    int m_retry;

    always #5 clk = ~clk;

    rx_bringup_sequencer #(
        .N_LANES(N_LANES), .NB_TIMEOUT(NB_TIMEOUT), .SETTLE_CYCLES(SETTLE),
        .RESET_CYCLES(RESET_CYCLES), .MAX_RETRIES(MAX_RETRIES), .NB_RETRY(NB_RETRY)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
        .i_rf_timeout_limit(limit), .i_lanes_block_lock(lanes_blk), .i_am_lock(am_lock),
        .i_invalid_skew(skew),
        .o_enb_block_sync(o_enb_block_sync), .o_enb_aligner(o_enb_aligner),
        .o_enb_deskewer(o_enb_deskewer), .o_enb_lane_reorder(o_enb_lane_reorder),
        .o_enb_descrambler(o_enb_descrambler), .o_enb_decoder(o_enb_decoder),
        .o_rx_soft_reset(o_rx_soft_reset), .o_busy(o_busy), .o_link_up(o_link_up),
        .o_fail(o_fail), .o_state(o_state), .o_retry_count(o_retry_count)
    );

    assign obs = {o_enb_block_sync, o_enb_aligner, o_enb_deskewer, o_enb_lane_reorder,
                  o_enb_descrambler, o_enb_decoder, o_rx_soft_reset, o_busy, o_link_up,
                  o_fail, o_state, o_retry_count};

    function automatic logic [14:0] exp_vec();
        int s;
        s = m_state;
        return {(s >= 1 && s <= 5), (s >= 2 && s <= 5), (s >= 3 && s <= 5),
                (s == 4 || s == 5), (s == 4 || s == 5), (s == 4 || s == 5),
                (s == 6), ((s >= 1 && s <= 4) || s == 6), (s == 5), (s == 7),
                3'(s), 2'(m_retry)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_streak = 0; m_retry = 0;
    endtask

    // One clock of the bring-up rules, using the inputs present at the edge
    task automatic model_tick();
        int  ns, nr, streak_now;
        bit  blk, am, dk, cond, waiting;
        blk  = &lanes_blk;
        am   = blk && (&am_lock);
        dk   = am && !skew;
        waiting = (m_state >= 1 && m_state <= 3);
        cond = (m_state == 1) ? blk : (m_state == 2) ? am : (m_state == 3) ? dk : 1'b0;
        streak_now = cond ? m_streak + 1 : 0;
        ns = m_state;
        nr = m_retry;
        if (waiting) begin
            if (streak_now == int'(SETTLE)) ns = m_state + 1;
            else if (limit != 0 && m_cnt + 1 >= int'(limit)) begin
                if (m_retry == int'(MAX_RETRIES)) ns = 7;
                else begin ns = 6; nr = m_retry + 1; end
            end
        end else begin
            case (m_state)
                4: ns = 5;
                5: if (!dk) begin ns = 6; nr = 1; end
                6: if (m_cnt + 1 == int'(RESET_CYCLES)) ns = 1;
                default: if (start) begin ns = 1; nr = 0; end
            endcase
        end
        if (abort) begin ns = 0; nr = 0; end
        if (ns != m_state || abort) begin
            m_cnt = 0; m_streak = 0;
        end else begin
            m_cnt++; m_streak = streak_now;
        end
        m_state = ns;
        m_retry = nr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; skew = 1'b0;
        limit = 24'd5; lanes_blk = '0; am_lock = '0;
        model_reset();
        #2;
        n_run++;
        if (obs !== 15'd0) begin n_fail++; $display("FAIL reset_initial: got %h expected 0", obs); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_run++;
        if (obs !== 15'd0) begin n_fail++; $display("FAIL reset_release: got %h expected 0", obs); end
        // Reach RESTART via a short timeout, then hit async reset in the middle of the pulse
        for (int c = 0; c < 7; c++) begin
            start = (c == 0);
            tick();
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
        end
        n_run++;
        if (o_rx_soft_reset !== 1'b1 || o_state !== 3'd6) begin
            n_fail++; $display("FAIL reset_pre_restart: got state %0d srst %b expected 6 1", o_state, o_rx_soft_reset);
        end
        rst = 1'b1;
        #2;
        n_run++;
        if (obs !== 15'd0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", obs); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_run++;
        if (obs !== exp_vec() || obs !== 15'd0) begin n_fail++; $display("FAIL reset_after: got %h expected 0", obs); end
    endtask

    task automatic test_nominal();
        int exp_st;
        apply_reset();
        limit = 24'd100; lanes_blk = '0; am_lock = '0; skew = 1'b0;
        for (int c = 0; c < 26; c++) begin
            start = (c == 0);
            if (c >= 3)  lanes_blk = '1;
            if (c >= 13) am_lock = '1;
            tick();
            exp_st = (c < 6) ? 1 : (c < 16) ? 2 : (c < 20) ? 3 : (c == 20) ? 4 : 5;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL nominal_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
            n_run++;
            if (o_state !== 3'(exp_st)) begin n_fail++; $display("FAIL nominal_state c=%0d: got %0d expected %0d", c, o_state, exp_st); end
        end
        n_run++;
        if (o_link_up !== 1'b1 || o_retry_count !== 2'd0 || o_enb_decoder !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL nominal_link: got link %b retry %0d dec %b busy %b expected 1 0 1 0",
                               o_link_up, o_retry_count, o_enb_decoder, o_busy);
        end
    endtask

    task automatic test_glitch();
        int exp_st;
        apply_reset();
        limit = 24'd100; lanes_blk = '0; am_lock = '0; skew = 1'b0;
        for (int c = 0; c < 11; c++) begin
            start = (c == 0);
            if (c >= 1) lanes_blk = '1;
            if (c == 4) lanes_blk[7] = 1'b0;
            tick();
            exp_st = (c < 8) ? 1 : 2;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
            n_run++;
            if (o_state !== 3'(exp_st)) begin n_fail++; $display("FAIL glitch_state c=%0d: got %0d expected %0d", c, o_state, exp_st); end
        end
    endtask

    task automatic test_timeout_fail();
        int exp_st, exp_retry, srst_cycles;
        apply_reset();
        limit = 24'd100; lanes_blk = '0; am_lock = '0; skew = 1'b0;
        srst_cycles = 0;
        for (int c = 0; c < 330; c++) begin
            start = (c == 0);
            tick();
            exp_st    = (c >= 316) ? 7 : ((c % 108) < 100) ? 1 : 6;
            exp_retry = (c < 100) ? 0 : (c < 208) ? 1 : 2;
            if (o_rx_soft_reset === 1'b1) srst_cycles++;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
            n_run++;
            if (o_state !== 3'(exp_st) || o_retry_count !== 2'(exp_retry)) begin
                n_fail++; $display("FAIL timeout_state c=%0d: got %0d/%0d expected %0d/%0d",
                                   c, o_state, o_retry_count, exp_st, exp_retry);
            end
        end
        n_run++;
        if (srst_cycles != 16) begin n_fail++; $display("FAIL timeout_srst_len: got %0d expected 16", srst_cycles); end
        n_run++;
        if (o_fail !== 1'b1 || o_enb_block_sync !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fail_flags: got fail %b blk %b busy %b expected 1 0 0", o_fail, o_enb_block_sync, o_busy);
        end
    endtask

    task automatic test_link_loss();
        int exp_st;
        apply_reset();
        limit = 24'd100; lanes_blk = '1; am_lock = '1; skew = 1'b0;
        for (int c = 0; c < 46; c++) begin
            start = (c == 0);
            skew  = (c == 20);
            tick();
            exp_st = (c < 4) ? 1 : (c < 8) ? 2 : (c < 12) ? 3 : (c == 12) ? 4 : (c < 20) ? 5 :
                     (c < 28) ? 6 : (c < 32) ? 1 : (c < 36) ? 2 : (c < 40) ? 3 : (c == 40) ? 4 : 5;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL linkloss_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
            n_run++;
            if (o_state !== 3'(exp_st) || o_retry_count !== ((c >= 20) ? 2'd1 : 2'd0)) begin
                n_fail++; $display("FAIL linkloss_state c=%0d: got %0d/%0d expected %0d/%0d",
                                   c, o_state, o_retry_count, exp_st, (c >= 20) ? 1 : 0);
            end
        end
    endtask

    task automatic test_abort();
        int exp_st;
        apply_reset();
        limit = 24'd100; lanes_blk = '1; am_lock = '0; skew = 1'b0;
        for (int c = 0; c < 12; c++) begin
            start = (c == 0) || (c == 6) || (c == 9);
            abort = (c == 6);
            tick();
            exp_st = (c < 4) ? 1 : (c < 6) ? 2 : (c < 9) ? 0 : 1;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL abort_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
            n_run++;
            if (o_state !== 3'(exp_st)) begin n_fail++; $display("FAIL abort_state c=%0d: got %0d expected %0d", c, o_state, exp_st); end
            if (c == 6) begin
                n_run++;
                if (obs !== 15'd0) begin n_fail++; $display("FAIL abort_outputs: got %h expected 0", obs); end
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_no_timeout();
        apply_reset();
        limit = 24'd0; lanes_blk = '0; am_lock = '0; skew = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            start = (c == 0);
            tick();
            n_run++;
            if (o_state !== 3'd1 || o_busy !== 1'b1 || o_rx_soft_reset !== 1'b0 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL notimeout c=%0d: got %h expected %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int link_seen;
        apply_reset();
        limit = 24'd40; skew = 1'b0;
        link_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 199) == 0);
            lanes_blk = '1;
            am_lock   = '1;
            if ($urandom_range(0, 29) == 0) lanes_blk[$urandom_range(0, N_LANES - 1)] = 1'b0;
            if ($urandom_range(0, 29) == 0) am_lock[$urandom_range(0, N_LANES - 1)] = 1'b0;
            skew = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) limit = 24'($urandom_range(0, 60));
            tick();
            if (m_state == 5) link_seen++;
            n_run++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_model c=%0d: got %h expected %h", c, obs, exp_vec()); end
        end
        abort = 1'b0;
        start = 1'b0;
        n_run++;
        if (link_seen == 0) begin n_fail++; $display("FAIL random_coverage: got 0 link-up cycles expected >0"); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout_fail();
        test_link_loss();
        test_abort();
        test_no_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
